// File: rtl/pipe_fetch_sched.sv
// Burst fetch scheduler: issues one BRAM read at a time and stages each
// 16-lane word in the downstream pipeline register until it is consumed.
module pipe_fetch_sched #(
  parameter int ADDR_W   = 12,
  parameter int BRAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [15:0]       last_mask,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       valid_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD, FIN
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(BRAM_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] remain;
  logic [15:0]       mask;
  logic [1:0]        wcnt;
  logic              empty;
  logic              is_last;

  assign is_last = (remain == ADDR_W'(1));

  // Lane enables fire only on the BRAM data-valid cycle; abort kills them.
  always_comb begin
    valid_data = 16'h0000;
    if (state == WAIT && wcnt == 2'd0 && !abort)
      valid_data = is_last ? mask : 16'hFFFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remain    <= '0;
      mask      <= '0;
      wcnt      <= '0;
      empty     <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            remain <= num_words;
            mask   <= (last_mask == 16'h0000) ? 16'hFFFF : last_mask;
            busy   <= 1'b1;
            if (num_words != '0) begin
              state   <= ISSUE;
              rd_en   <= 1'b1;
              rd_addr <= base_addr;
            end else begin
              state <= FIN;
              empty <= 1'b1;
            end
          end
        end
        ISSUE: begin
          rd_en <= 1'b0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
            wcnt  <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wcnt == 2'd0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_last  <= is_last;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        HOLD: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (is_last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              remain  <= remain - ADDR_W'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
              rd_en   <= 1'b1;
            end
          end
        end
        FIN: begin
          // An empty burst lingers one extra cycle before pulsing done.
          if (empty) begin
            empty <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_sched.sv
// Bench for pipe_fetch_sched: directed timelines plus a randomized run
// checked every cycle against a word/offset level reference model.
module tb_pipe_fetch_sched;

  localparam int AW  = 12;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic [15:0]   last_mask = '0;
  logic          abort = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   valid_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  pipe_fetch_sched #(.ADDR_W(AW), .BRAM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .last_mask(last_mask), .abort(abort), .rd_en(rd_en),
    .rd_addr(rd_addr), .valid_data(valid_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int t0 = 0;

  logic          h_rd [64];
  logic [AW-1:0] h_ad [64];
  logic [15:0]   h_vd [64];
  logic          h_ov [64];
  logic          h_la [64];
  logic          h_bz [64];
  logic          h_dn [64];

  // Reference model: 0 idle, 1 fetching, 2 empty burst pending, 3 done pulse.
  int            m_ph;
  int            m_left;
  int            m_off;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_mask;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_ph = 0; m_left = 0; m_off = 0; m_addr = '0; m_mask = '0;
  endtask

  task automatic model_step();
    case (m_ph)
      0: if (start) begin
        if (num_words != '0) begin
          m_ph = 1; m_left = int'(num_words); m_addr = base_addr;
          m_off = 0;
          m_mask = (last_mask == 16'h0) ? 16'hFFFF : last_mask;
        end else m_ph = 2;
      end
      1: if (abort) m_ph = 0;
         else if (m_off > LAT) begin
           if (out_ready) begin
             if (m_left == 1) m_ph = 3;
             else begin
               m_left--; m_addr = m_addr + 1'b1; m_off = 0;
             end
           end
         end else m_off++;
      2: m_ph = 3;
      default: m_ph = 0;
    endcase
  endtask

  task automatic compare();
    logic          e_rd, e_ov, e_la;
    logic [15:0]   e_vd;
    e_rd = (m_ph == 1 && m_off == 0);
    e_vd = (m_ph == 1 && m_off == LAT && !abort)
         ? ((m_left == 1) ? m_mask : 16'hFFFF) : 16'h0;
    e_ov = (m_ph == 1 && m_off > LAT);
    e_la = e_ov && m_left == 1;
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
    chk("valid_data", 32'(valid_data), 32'(e_vd));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_last", 32'(out_last), 32'(e_la));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("done", 32'(done), 32'(m_ph == 3));
  endtask

  task automatic tick();
    int k;
    @(negedge clk);
    k = cyc - t0;
    if (k >= 0 && k < 64) begin
      h_rd[k] = rd_en; h_ad[k] = rd_addr; h_vd[k] = valid_data;
      h_ov[k] = out_valid; h_la[k] = out_last;
      h_bz[k] = busy; h_dn[k] = done;
    end
    compare();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    start = 0; abort = 0; out_ready = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] n,
                    input logic [15:0] m);
    start = 1; base_addr = b; num_words = n; last_mask = m;
  endtask

  initial begin
    logic [15:0] acc;
    int nrd;
    model_reset();
    #12;
    chk("reset_outs",
        32'({rd_en, rd_addr, valid_data, out_valid, out_last, busy, done}),
        32'(0));
    @(posedge clk); #1;
    reset_n = 1;
    idle(3);

    // Single word, partial mask.
    t0 = cyc;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) go(12'h010, 12'd1, 16'h00FF); else start = 0;
      tick();
    end
    chk("t1_rd_en1", 32'(h_rd[1]), 32'(1));
    chk("t1_addr1", 32'(h_ad[1]), 32'h010);
    chk("t1_vd3", 32'(h_vd[3]), 32'h00FF);
    chk("t1_vd2", 32'(h_vd[2]), 32'h0);
    chk("t1_ovl4", 32'({h_ov[4], h_la[4]}), 32'h3);
    chk("t1_done5", 32'({h_dn[4], h_dn[5]}), 32'h1);
    chk("t1_busy6", 32'({h_bz[5], h_bz[6]}), 32'h2);

    // Address wrap, zero mask promoted to all lanes.
    idle(2);
    t0 = cyc;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) go(12'hFFE, 12'd3, 16'h0000); else start = 0;
      tick();
    end
    chk("t2_rd", 32'({h_rd[1], h_rd[5], h_rd[9], h_rd[3]}), 32'hE);
    chk("t2_addr", 32'({h_ad[1], h_ad[5], h_ad[9]}),
        32'({12'hFFE, 12'hFFF, 12'h000}));
    chk("t2_vd11", 32'(h_vd[11]), 32'hFFFF);
    chk("t2_last", 32'({h_la[4], h_la[8], h_la[12]}), 32'h1);
    chk("t2_done13", 32'({h_dn[12], h_dn[13]}), 32'h1);

    // Downstream stall.
    idle(2);
    t0 = cyc;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) go(12'h020, 12'd2, 16'h0F0F); else start = 0;
      out_ready = !(c >= 4 && c <= 7);
      tick();
    end
    acc = '0;
    for (int c = 4; c <= 8; c++) acc |= h_vd[c];
    chk("t3_hold", 32'({h_ov[4], h_ov[8], h_ov[9]}), 32'h6);
    chk("t3_stall_vd", 32'(acc), 32'h0);
    chk("t3_rd9", 32'({h_rd[9], h_ad[9]}), 32'({1'b1, 12'h021}));
    chk("t3_vd11", 32'(h_vd[11]), 32'h0F0F);

    // Empty burst; second start while busy ignored.
    idle(2);
    t0 = cyc;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) go(12'h050, 12'd0, 16'h1234);
      else if (c == 1) go(12'h060, 12'd2, 16'h1234);
      else start = 0;
      tick();
    end
    nrd = 0; acc = '0;
    for (int c = 0; c < 8; c++) begin
      nrd += int'(h_rd[c]); acc |= h_vd[c];
    end
    chk("t4_no_rd", 32'(nrd), 32'(0));
    chk("t4_no_vd", 32'(acc), 32'h0);
    chk("t4_done2", 32'({h_dn[1], h_dn[2], h_dn[3]}), 32'h2);
    chk("t4_busy", 32'({h_bz[1], h_bz[3]}), 32'h2);

    // Abort mid-wait, then restart right away.
    idle(2);
    t0 = cyc;
    for (int c = 0; c < 12; c++) begin
      start = 0; abort = (c == 2);
      if (c == 0) go(12'h080, 12'd4, 16'h0000);
      if (c == 3) go(12'h100, 12'd1, 16'h0000);
      tick();
    end
    abort = 0;
    chk("t5_idle3", 32'({h_bz[2], h_bz[3]}), 32'h2);
    chk("t5_vd3", 32'(h_vd[3]), 32'h0);
    chk("t5_restart", 32'({h_rd[4], h_ad[4]}), 32'({1'b1, 12'h100}));
    chk("t5_vd6", 32'(h_vd[6]), 32'hFFFF);
    chk("t5_nodone", 32'({h_dn[2], h_dn[3], h_dn[4]}), 32'h0);

    // Asynchronous reset while holding a word.
    idle(2);
    t0 = cyc;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) go(12'h200, 12'd2, 16'h0000); else start = 0;
      out_ready = 0;
      tick();
    end
    chk("t6_holding", 32'(out_valid), 32'(1));
    reset_n = 0;
    model_reset();
    #1;
    chk("t6_async",
        32'({rd_en, rd_addr, valid_data, out_valid, out_last, busy, done}),
        32'(0));
    tick();
    reset_n = 1;
    out_ready = 1;
    t0 = cyc;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) go(12'h300, 12'd1, 16'h0000); else start = 0;
      tick();
    end
    chk("t6_newbase", 32'({h_rd[1], h_ad[1]}), 32'({1'b1, 12'h300}));
    chk("t6_done5", 32'(h_dn[5]), 32'(1));

    // Longest burst: counter must not overflow.
    idle(2);
    t0 = cyc;
    go(12'h7A5, 12'hFFF, 16'h8001);
    tick();
    start = 0;
    for (int c = 0; c < 4095 * (LAT + 2) + 4; c++) tick();
    chk("t7_done_end", 32'(h_bz[0]), 32'(0));

    // Randomized traffic.
    t0 = cyc + 1000000;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      base_addr = AW'($urandom);
      num_words = ($urandom_range(0, 9) == 0) ? '0
                : AW'($urandom_range(1, 5));
      last_mask = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      abort = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
